// File: rtl/sysid_pkg.sv
// Shared constants for the sysid register block: word addresses, CTRL bit
// positions, CAPS version and the byte-lane merge helper.
package sysid_pkg;

    localparam logic [31:0] ADDR_ID      = 32'd0;
    localparam logic [31:0] ADDR_TSTAMP  = 32'd1;
    localparam logic [31:0] ADDR_UP_LO   = 32'd2;
    localparam logic [31:0] ADDR_UP_HI   = 32'd3;
    localparam logic [31:0] ADDR_SCRATCH = 32'd4;
    localparam logic [31:0] ADDR_CTRL    = 32'd5;
    localparam logic [31:0] ADDR_CAPS    = 32'd6;
    localparam logic [31:0] ADDR_USER0   = 32'd8;

    localparam int unsigned CTRL_FREEZE = 0;
    localparam int unsigned CTRL_CLEAR  = 1;
    localparam int unsigned CTRL_OVF    = 8;

    localparam logic [7:0] CAPS_VERSION = 8'h02;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with freeze and synchronous clear; wrap is
// high in the cycle whose clock edge takes the counter from all-ones to zero.
module sysid_uptime_counter #(
    parameter int UPTIME_W = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                freeze,
    input  logic                clear,
    output logic [UPTIME_W-1:0] count,
    output logic                wrap
);

    logic [UPTIME_W-1:0] count_r;

    assign count = count_r;
    // Clear has priority, so a clear landing on the wrap edge never reports a wrap.
    assign wrap  = (&count_r) && !freeze && !clear;

    // Counter state: clear beats freeze beats increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {UPTIME_W{1'b0}};
        end else if (clear) begin
            count_r <= {UPTIME_W{1'b0}};
        end else if (!freeze) begin
            count_r <= count_r + UPTIME_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/sysid_regs_avmm.sv
// Avalon-MM system ID / uptime register block with fixed read latency of one
// cycle; holds the register file, write decode and read mux.
module sysid_regs_avmm
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYS_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'd0,
    parameter int          NUM_USER  = 4,
    parameter int          UPTIME_W  = 64,
    parameter int          ADDR_W    = 5
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [ADDR_W-1:0]                         address,
    input  logic                                      read,
    input  logic                                      write,
    input  logic [31:0]                               writedata,
    input  logic [3:0]                                byteenable,
    output logic [31:0]                               readdata,
    output logic                                      readdatavalid,
    input  logic [((NUM_USER > 0) ? 32*NUM_USER : 32)-1:0] user_info,
    output logic                                      uptime_ovf
);

    logic [31:0]         addr_s;
    logic                wr_ctrl_s;
    logic                clear_s;
    logic                wrap_s;
    logic [UPTIME_W-1:0] count_s;
    logic [31:0]         rd_mux_s;

    logic [31:0] scratch_r;
    logic [31:0] hi_shadow_r;
    logic        freeze_r;
    logic        ovf_r;

    assign addr_s     = 32'(address);
    assign wr_ctrl_s  = write && (addr_s == ADDR_CTRL);
    assign clear_s    = wr_ctrl_s && byteenable[0] && writedata[CTRL_CLEAR];
    assign uptime_ovf = ovf_r;

    sysid_uptime_counter #(
        .UPTIME_W (UPTIME_W)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .freeze (freeze_r),
        .clear  (clear_s),
        .count  (count_s),
        .wrap   (wrap_s)
    );

    // Register file updates; a wrap on the same edge as an OVF clear keeps OVF set.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch_r   <= 32'h0;
            hi_shadow_r <= 32'h0;
            freeze_r    <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            if (write && (addr_s == ADDR_SCRATCH)) begin
                scratch_r <= be_merge(scratch_r, writedata, byteenable);
            end
            if (wr_ctrl_s && byteenable[0]) begin
                freeze_r <= writedata[CTRL_FREEZE];
            end
            if (wrap_s) begin
                ovf_r <= 1'b1;
            end else if (wr_ctrl_s && byteenable[1] && writedata[CTRL_OVF]) begin
                ovf_r <= 1'b0;
            end
            // Upper half captured with the low read so software sees a coherent pair.
            if (read && (addr_s == ADDR_UP_LO)) begin
                hi_shadow_r <= 32'(count_s >> 32);
            end
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux_s = 32'h0;
        case (addr_s)
            ADDR_ID:      rd_mux_s = SYS_ID;
            ADDR_TSTAMP:  rd_mux_s = TIMESTAMP;
            ADDR_UP_LO:   rd_mux_s = count_s[31:0];
            ADDR_UP_HI:   rd_mux_s = hi_shadow_r;
            ADDR_SCRATCH: rd_mux_s = scratch_r;
            ADDR_CTRL:    rd_mux_s = {23'd0, ovf_r, 7'd0, freeze_r};
            ADDR_CAPS:    rd_mux_s = {CAPS_VERSION, 8'd0, 8'(UPTIME_W), 8'(NUM_USER)};
            default: begin
                for (int k = 0; k < NUM_USER; k++) begin
                    rd_mux_s = (addr_s == (ADDR_USER0 + 32'(k))) ? user_info[32*k +: 32]
                                                                  : rd_mux_s;
                end
            end
        endcase
    end

    // Registered read response; readdata holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux_s;
            end else begin
                readdata <= readdata;
            end
        end
    end

endmodule

// File: tb/tb_sysid_regs_avmm.sv
// Bench for sysid_regs_avmm: directed transfers, a behavioural model checked
// every cycle, plus literal expectations on selected reads.
module tb_sysid_regs_avmm;

    localparam int          UW       = 33;
    localparam logic [31:0] SYS_ID_T = 32'hC0DE_5A5A;
    localparam logic [31:0] TSTAMP_T = 32'h6543_2100;
    localparam longint      MAXC     = (longint'(1) << UW) - 64'sd1;

    logic         clock      = 1'b0;
    logic         reset      = 1'b1;
    logic [4:0]   address    = 5'd0;
    logic         read       = 1'b0;
    logic         write      = 1'b0;
    logic [31:0]  writedata  = 32'h0;
    logic [3:0]   byteenable = 4'h0;
    logic [127:0] user_info  = 128'h0;

    logic [31:0] rd33, rddef;
    logic        rdv33, rdvdef, ovf33, ovfdef;

    always #5 clock = ~clock;

    sysid_regs_avmm #(
        .SYS_ID(SYS_ID_T), .TIMESTAMP(TSTAMP_T), .NUM_USER(4), .UPTIME_W(UW), .ADDR_W(5)
    ) dut33 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd33),
        .readdatavalid(rdv33), .user_info(user_info), .uptime_ovf(ovf33)
    );

    sysid_regs_avmm dutdef (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rddef),
        .readdatavalid(rdvdef), .user_info(user_info), .uptime_ovf(ovfdef)
    );

    // Model state
    longint      m_cnt = 0;
    logic [31:0] m_hi = 32'h0, m_scr = 32'h0, m_rd = 32'h0;
    logic        m_frz = 1'b0, m_ovf = 1'b0, m_rdv = 1'b0;
    logic        pre_req = 1'b0;
    longint      pre_val = 0;

    wire        m_wctrl = write && (address == 5'd5);
    wire        m_clr   = m_wctrl && byteenable[0] && writedata[1];
    wire        m_w1c   = m_wctrl && byteenable[1] && writedata[8];
    wire        m_wrap  = !m_clr && !m_frz && (m_cnt == MAXC);
    wire [31:0] m_mask  = {{8{byteenable[3]}}, {8{byteenable[2]}},
                           {8{byteenable[1]}}, {8{byteenable[0]}}};

    function automatic logic [31:0] model_read(input int a);
        if (a == 0) return SYS_ID_T;
        if (a == 1) return TSTAMP_T;
        if (a == 2) return 32'(m_cnt);
        if (a == 3) return m_hi;
        if (a == 4) return m_scr;
        if (a == 5) return (m_ovf ? 32'h100 : 32'h0) | (m_frz ? 32'h1 : 32'h0);
        if (a == 6) return {8'h02, 8'h00, 8'(UW), 8'd4};
        if (a >= 8 && a < 12) return user_info[32*(a-8) +: 32];
        return 32'h0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_cnt <= 0; m_hi <= 32'h0; m_scr <= 32'h0; m_rd <= 32'h0;
            m_frz <= 1'b0; m_ovf <= 1'b0; m_rdv <= 1'b0;
        end else begin
            m_rdv <= read;
            if (read) m_rd <= model_read(int'(address));
            if (read && address == 5'd2) m_hi <= 32'(m_cnt >> 32);
            if (pre_req) m_cnt <= pre_val;
            else if (m_clr) m_cnt <= 0;
            else if (!m_frz) m_cnt <= (m_cnt + 1) % (MAXC + 1);
            if (m_wctrl && byteenable[0]) m_frz <= writedata[0];
            if (m_wrap) m_ovf <= 1'b1;
            else if (m_w1c) m_ovf <= 1'b0;
            if (write && address == 5'd4) m_scr <= (m_scr & ~m_mask) | (writedata & m_mask);
        end
    end

    // Literal expectation requests, consumed by the compare process
    logic        chk_on = 1'b0;
    logic        lit33_en = 1'b0, litdef_en = 1'b0, litovf_en = 1'b0, litrdv_en = 1'b0;
    logic [31:0] lit33_exp = 32'h0, litdef_exp = 32'h0;
    logic        lit_ovf_exp = 1'b0, lit_rdv_exp = 1'b0;
    string       lit_name = "";
    logic [31:0] exp_u [4] = '{32'hCAFE_0000, 32'hCAFE_0101, 32'hCAFE_0202, 32'hCAFE_0303};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        if (chk_on) begin
            check("model_rdv", {31'd0, rdv33}, {31'd0, m_rdv});
            check("model_readdata", rd33, m_rd);
            check("model_uptime_ovf", {31'd0, ovf33}, {31'd0, m_ovf});
            if (lit33_en)  check(lit_name, rd33, lit33_exp);
            if (litdef_en) check({lit_name, "_default"}, rddef, litdef_exp);
            if (litovf_en) check(lit_name, {31'd0, ovf33}, {31'd0, lit_ovf_exp});
            if (litrdv_en) check(lit_name, {31'd0, rdv33}, {31'd0, lit_rdv_exp});
        end
    end

    task automatic bus(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        read = r; write = w; address = a; writedata = d; byteenable = be;
        lit33_en = 1'b0; litdef_en = 1'b0; litovf_en = 1'b0; litrdv_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        bus(1'b1, 1'b0, a, 32'h0, 4'h0);
        lit33_en = 1'b1; lit33_exp = e; lit_name = n;
        litrdv_en = 1'b1; lit_rdv_exp = 1'b1;
    endtask

    task automatic rd_def(input logic [4:0] a, input logic [31:0] e33,
                          input logic [31:0] edef, input string n);
        rd(a, e33, n);
        litdef_en = 1'b1; litdef_exp = edef;
    endtask

    task automatic expect_ovf(input logic e, input string n);
        idle(1);
        litovf_en = 1'b1; lit_ovf_exp = e; lit_name = n;
    endtask

    // Loads the counter directly while frozen, then unfreezes; the count starts
    // moving on the second cycle after this task returns.
    task automatic arm(input longint v);
        wr(5'd5, 32'h1, 4'h1);
        idle(1);
        pre_val = v;
        force dut33.u_counter.count_r = pre_val[UW-1:0];
        pre_req = 1'b1;
        @(negedge clock);
        release dut33.u_counter.count_r;
        pre_req = 1'b0;
        wr(5'd5, 32'h0, 4'h1);
    endtask

    initial begin
        idle(1);
        chk_on = 1'b1;
        idle(1);
        reset = 1'b0;

        // Identity and capabilities, back-to-back reads
        rd_def(5'd0, SYS_ID_T, 32'h0000_0000, "id");
        rd_def(5'd1, TSTAMP_T, 32'h0000_0000, "tstamp");
        rd_def(5'd6, 32'h0200_2104, 32'h0200_4004, "caps");
        idle(1);
        litrdv_en = 1'b1; lit_rdv_exp = 1'b0; lit_name = "rdv_idle";

        // Scratch byte lanes, read+write same cycle, unmapped address
        wr(5'd4, 32'hFFFF_FFFF, 4'hF);
        wr(5'd4, 32'h1234_5678, 4'b0101);
        rd(5'd4, 32'hFF34_FF78, "scratch_be");
        bus(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 4'hF);
        lit33_en = 1'b1; lit33_exp = 32'hFF34_FF78; lit_name = "rw_same_cycle";
        rd(5'd4, 32'hDEAD_BEEF, "scratch_after_rw");
        wr(5'd31, 32'h0, 4'hF);
        rd(5'd31, 32'h0, "unmapped_read");
        rd(5'd4, 32'hDEAD_BEEF, "unmapped_write_ignored");

        // Freeze+clear in one transfer, then coherent UP_LO/UP_HI across a carry
        wr(5'd5, 32'h3, 4'h1);
        rd(5'd2, 32'h0, "clear_freeze");
        idle(2);
        rd(5'd2, 32'h0, "frozen_hold");
        rd(5'd5, 32'h1, "ctrl_freeze_clear_reads0");
        arm(64'sh0_FFFF_FFFD);
        rd(5'd2, 32'hFFFF_FFFD, "uplo_precarry");
        idle(3);
        rd(5'd3, 32'h0, "uphi_coherent");
        bus(1'b1, 1'b0, 5'd2, 32'h0, 4'h0);
        rd(5'd3, 32'h1, "uphi_after_carry");

        // Wrap, OVF set/clear interplay, CLEAR on the wrap cycle
        arm(MAXC - 1);
        idle(2);
        expect_ovf(1'b1, "ovf_set_on_wrap");
        rd(5'd5, 32'h100, "ctrl_ovf");
        arm(MAXC - 1);
        idle(1);
        wr(5'd5, 32'h100, 4'b0010);
        expect_ovf(1'b1, "ovf_set_beats_w1c");
        wr(5'd5, 32'h100, 4'b0010);
        expect_ovf(1'b0, "ovf_w1c");
        arm(MAXC - 1);
        idle(1);
        wr(5'd5, 32'h2, 4'b0001);
        expect_ovf(1'b0, "clear_beats_wrap");
        rd(5'd2, 32'h1, "count_after_clear");

        // User words changing every cycle under back-to-back reads
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 1'b0, 5'(8 + i), 32'h0, 4'h0);
            for (int k = 0; k < 4; k++) user_info[32*k +: 32] = 32'hCAFE_0000 + 32'(i*256 + k);
            lit33_en = 1'b1; lit33_exp = exp_u[i]; lit_name = "user_word";
        end
        idle(1);
        user_info = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
        rd(5'd11, 32'h0123_4567, "user3_static");

        // Reset the cycle after a read, and a read under reset
        wr(5'd4, 32'h5555_AAAA, 4'hF);
        bus(1'b1, 1'b0, 5'd4, 32'h0, 4'h0);
        idle(1);
        reset = 1'b1;
        litrdv_en = 1'b1; lit_rdv_exp = 1'b0; lit_name = "rdv_dropped";
        bus(1'b1, 1'b0, 5'd4, 32'h0, 4'h0);
        litrdv_en = 1'b1; lit_rdv_exp = 1'b0; lit_name = "rdv_under_reset";
        idle(1);
        reset = 1'b0;
        rd(5'd4, 32'h0, "scratch_reset");
        idle(1);
        rd(5'd2, 32'h3, "count_reset");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
